// File: rtl/int_to_float_fpu.sv
// Sequential signed 32-bit integer to IEEE-754 single-precision converter.
// Normalises one bit per cycle, then applies round-to-nearest-even before packing.
//
// state        | meaning
// -------------+------------------------------------------------------------
// st_get_a     | input_a_ack high, waiting for an operand handshake
// st_convert_0 | zero detect, sign/magnitude split, exponent seeded at 31
// st_convert_1 | normalise: shift magnitude left until bit 31 is set
// st_convert_2 | split the normalised magnitude into mantissa/guard/round/sticky
// st_round     | round to nearest even, carrying into the exponent on wrap
// st_pack      | assemble sign, biased exponent and fraction into z
// st_put_z     | output_z_stb high, holding z until the consumer acks
module int_to_float_fpu (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  typedef enum logic [2:0] {
    st_get_a,
    st_convert_0,
    st_convert_1,
    st_convert_2,
    st_round,
    st_pack,
    st_put_z
  } state_t;

  state_t state, state_nxt;

  logic               input_a_ack_nxt;
  logic               output_z_stb_nxt;
  logic [31:0]        output_z_nxt;

  logic [31:0]        a, a_nxt;
  logic [31:0]        value, value_nxt;
  logic [23:0]        z_m, z_m_nxt;
  logic signed [9:0]  z_e, z_e_nxt;
  logic               z_s, z_s_nxt;
  logic               guard, guard_nxt;
  logic               round_bit, round_bit_nxt;
  logic               sticky, sticky_nxt;
  logic [31:0]        z, z_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= st_get_a;
      input_a_ack  <= 1'b0;
      output_z_stb <= 1'b0;
      output_z     <= 32'h0000_0000;
    end else begin
      state        <= state_nxt;
      input_a_ack  <= input_a_ack_nxt;
      output_z_stb <= output_z_stb_nxt;
      output_z     <= output_z_nxt;
    end
  end

  // Datapath is always rewritten before use, so it carries no reset.
  always_ff @(posedge clk) begin
    a         <= a_nxt;
    value     <= value_nxt;
    z_m       <= z_m_nxt;
    z_e       <= z_e_nxt;
    z_s       <= z_s_nxt;
    guard     <= guard_nxt;
    round_bit <= round_bit_nxt;
    sticky    <= sticky_nxt;
    z         <= z_nxt;
  end

  always_comb begin
    state_nxt        = state;
    input_a_ack_nxt  = input_a_ack;
    output_z_stb_nxt = output_z_stb;
    output_z_nxt     = output_z;
    a_nxt            = a;
    value_nxt        = value;
    z_m_nxt          = z_m;
    z_e_nxt          = z_e;
    z_s_nxt          = z_s;
    guard_nxt        = guard;
    round_bit_nxt    = round_bit;
    sticky_nxt       = sticky;
    z_nxt            = z;

    case (state)
      st_get_a: begin
        input_a_ack_nxt = 1'b1;
        if (input_a_ack && input_a_stb) begin
          a_nxt           = input_a;
          input_a_ack_nxt = 1'b0;
          state_nxt       = st_convert_0;
        end
      end

      st_convert_0: begin
        if (a == 32'h0000_0000) begin
          z_nxt     = 32'h0000_0000;
          state_nxt = st_put_z;
        end else begin
          z_s_nxt   = a[31];
          // Negating 0x80000000 wraps back to itself, which is the right magnitude.
          value_nxt = a[31] ? (~a + 32'd1) : a;
          z_e_nxt   = 10'sd31;
          state_nxt = st_convert_1;
        end
      end

      st_convert_1: begin
        if (!value[31]) begin
          value_nxt = {value[30:0], 1'b0};
          z_e_nxt   = z_e - 10'sd1;
        end else begin
          state_nxt = st_convert_2;
        end
      end

      st_convert_2: begin
        z_m_nxt       = value[31:8];
        guard_nxt     = value[7];
        round_bit_nxt = value[6];
        sticky_nxt    = |value[5:0];
        state_nxt     = st_round;
      end

      st_round: begin
        if (guard && (round_bit || sticky || z_m[0])) begin
          z_m_nxt = z_m + 24'd1;
          if (z_m == 24'hFF_FFFF) z_e_nxt = z_e + 10'sd1;
        end
        state_nxt = st_pack;
      end

      st_pack: begin
        z_nxt     = {z_s, z_e[7:0] + 8'd127, z_m[22:0]};
        state_nxt = st_put_z;
      end

      st_put_z: begin
        output_z_stb_nxt = 1'b1;
        output_z_nxt     = z;
        if (output_z_stb && output_z_ack) begin
          output_z_stb_nxt = 1'b0;
          state_nxt        = st_get_a;
        end
      end

      default: begin
        state_nxt        = st_get_a;
        input_a_ack_nxt  = 1'b0;
        output_z_stb_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_int_to_float_fpu.sv
// Self-checking bench for int_to_float_fpu: directed corner cases plus random
// operands compared against an arithmetic round-to-nearest-even reference.
module tb_int_to_float_fpu;

  logic        clk;
  logic        rst;
  logic [31:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;

  int n_checks = 0;
  int n_fail   = 0;

  int_to_float_fpu dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic int msb_pos(input logic [63:0] m);
    int p = 0;
    for (int i = 0; i < 64; i++) if (m[i]) p = i;
    return p;
  endfunction

  function automatic logic [63:0] magnitude(input logic [31:0] v);
    return v[31] ? (64'd4294967296 - {32'd0, v}) : {32'd0, v};
  endfunction

  // Exact integer value rounded to 24 significant bits, ties to even.
  function automatic logic [31:0] ref_float(input logic [31:0] v);
    logic [63:0] mag, q, rem, half;
    int p, sh;
    logic [7:0] e;
    if (v == 32'd0) return 32'd0;
    mag = magnitude(v);
    p = msb_pos(mag);
    if (p <= 23) begin
      q = mag << (23 - p);
    end else begin
      sh   = p - 23;
      q    = mag >> sh;
      rem  = mag & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 64'd1;
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        p = p + 1;
      end
    end
    e = 8'(p + 127);
    return {v[31], e, q[22:0]};
  endfunction

  task automatic convert(input logic [31:0] v, input int hold, output logic [31:0] got);
    logic [31:0] expz, held;
    int explat, edges;
    expz   = ref_float(v);
    explat = (v == 32'd0) ? 2 : (31 - msb_pos(magnitude(v))) + 6;
    for (int i = 0; i < 10 && !input_a_ack; i++) begin
      @(posedge clk); #1;
    end
    check("ack_ready", 32'(input_a_ack), 32'd1);
    input_a     = v;
    input_a_stb = 1'b1;
    @(posedge clk); #1;
    input_a_stb = 1'b0;
    input_a     = $urandom;
    edges = 0;
    while (!output_z_stb && edges < 60) begin
      @(posedge clk); #1;
      edges++;
    end
    check("latency", 32'(edges), 32'(explat));
    check("result", output_z, expz);
    got  = output_z;
    held = output_z;
    input_a_stb = (hold > 0);
    repeat (hold) begin
      @(posedge clk); #1;
      check("bp_stb", 32'(output_z_stb), 32'd1);
      check("bp_hold", output_z, held);
      check("bp_no_ack", 32'(input_a_ack), 32'd0);
    end
    input_a_stb  = 1'b0;
    output_z_ack = 1'b1;
    @(posedge clk); #1;
    output_z_ack = 1'b0;
    check("stb_drop", 32'(output_z_stb), 32'd0);
    check("ack_low", 32'(input_a_ack), 32'd0);
    @(posedge clk); #1;
    check("ack_return", 32'(input_a_ack), 32'd1);
  endtask

  logic [31:0] dir_in  [8] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 32'h7FFF_FFFF,
                               32'h8000_0000, 32'h0100_0001, 32'h0100_0003, 32'h0000_0005};
  logic [31:0] dir_exp [8] = '{32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 32'h4F00_0000,
                               32'hCF00_0000, 32'h4B80_0000, 32'h4B80_0002, 32'h40A0_0000};

  initial begin
    logic [31:0] got, v;
    int stale;
    rst          = 1'b0;
    input_a      = 32'd0;
    input_a_stb  = 1'b0;
    output_z_ack = 1'b0;
    #12;
    check("rst_ack", 32'(input_a_ack), 32'd0);
    check("rst_stb", 32'(output_z_stb), 32'd0);
    check("rst_z", output_z, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("first_ack", 32'(input_a_ack), 32'd1);

    for (int i = 0; i < 8; i++) begin
      convert(dir_in[i], 0, got);
      check("directed", got, dir_exp[i]);
    end

    convert(32'h1234_5678, 20, got);

    // Abort a conversion of 1 while it is still normalising.
    convert(32'hDEAD_BEEF, 0, got);
    input_a     = 32'd1;
    input_a_stb = 1'b1;
    @(posedge clk); #1;
    input_a_stb = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("mid_rst_ack", 32'(input_a_ack), 32'd0);
    check("mid_rst_stb", 32'(output_z_stb), 32'd0);
    check("mid_rst_z", output_z, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    stale = 0;
    repeat (45) begin
      @(posedge clk); #1;
      if (output_z_stb) stale++;
    end
    check("no_stale", 32'(stale), 32'd0);
    convert(32'd5, 0, got);
    check("after_rst", got, 32'h40A0_0000);

    for (int i = 0; i < 300; i++) begin
      v = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) v = -v;
      convert(v, $urandom_range(0, 3), got);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
